// File: rtl/cpu_controller_if.sv
// Control bundle between cpu_controller (master) and the PC/datapath stages (slave).
interface cpu_controller_if #(
   parameter int IMM_W = 16
);
   logic [15:0]      IR;
   logic             loadir;
   logic             incp;
   logic             execb;
   logic             msel;
   logic             mwrite;
   logic [2:0]       cond;
   logic [IMM_W-1:0] sximm8;
   logic [IMM_W-1:0] sximm5;
   logic [2:0]       readnum;
   logic [2:0]       writenum;
   logic             write;
   logic             loada;
   logic             loadb;
   logic             loadc;
   logic             loads;
   logic             asel;
   logic             bsel;
   logic [1:0]       vsel;
   logic [1:0]       ALUop;
   logic [1:0]       shift;
   logic             halted;
   logic             illegal;

   modport master (
      input  IR,
      output loadir, incp, execb, msel, mwrite, cond, sximm8, sximm5,
             readnum, writenum, write, loada, loadb, loadc, loads, asel, bsel,
             vsel, ALUop, shift, halted, illegal
   );

   modport slave (
      output IR,
      input  loadir, incp, execb, msel, mwrite, cond, sximm8, sximm5,
             readnum, writenum, write, loada, loadb, loadc, loads, asel, bsel,
             vsel, ALUop, shift, halted, illegal
   );
endinterface

// File: rtl/cpu_controller.sv
// Moore instruction sequencer for the 16-bit lab CPU; outputs are registered from the next state.
// Optional trap on undefined encodings: define CTRL_ILLEGAL_TRAP_EN.
module cpu_controller #(
   parameter int IMM_W = 16
) (
   input  logic              clk,
   input  logic              reset,
   cpu_controller_if.master  bus
);
   localparam logic [4:0] RST   = 5'd0,  IF1   = 5'd1,  IF2   = 5'd2,  UPDPC = 5'd3;
   localparam logic [4:0] DEC   = 5'd4,  WRIMM = 5'd5,  GETA  = 5'd6,  GETB  = 5'd7;
   localparam logic [4:0] GETBD = 5'd8,  MOVC  = 5'd9,  ALUC  = 5'd10, CMPS  = 5'd11;
   localparam logic [4:0] WRC   = 5'd12, ADDR  = 5'd13, LDRRD = 5'd14, LDRWR = 5'd15;
   localparam logic [4:0] STRWR = 5'd16, BR    = 5'd17, HALT  = 5'd18;

   logic [4:0] state_q, state_d;
   logic [2:0] opc_s;
   logic [1:0] op_s;
   logic is_movi_s, is_movr_s, is_mvn_s, is_add_s, is_and_s, is_cmp_s;
   logic is_ldr_s, is_str_s, is_b_s, is_halt_s;

   logic loadir_q, incp_q, execb_q, msel_q, mwrite_q, write_q;
   logic loada_q, loadb_q, loadc_q, loads_q, asel_q, bsel_q, halted_q;
   logic loadir_d, incp_d, execb_d, msel_d, mwrite_d, write_d;
   logic loada_d, loadb_d, loadc_d, loads_d, asel_d, bsel_d, halted_d;
   logic [2:0] readnum_q, writenum_q, readnum_d, writenum_d;
   logic [1:0] vsel_q, shift_q, vsel_d, shift_d;

   assign opc_s     = bus.IR[15:13];
   assign op_s      = bus.IR[12:11];
   assign is_movi_s = (opc_s == 3'b110) && (op_s == 2'b10);
   assign is_movr_s = (opc_s == 3'b110) && (op_s == 2'b00);
   assign is_mvn_s  = (opc_s == 3'b101) && (op_s == 2'b11);
   assign is_add_s  = (opc_s == 3'b101) && (op_s == 2'b00);
   assign is_and_s  = (opc_s == 3'b101) && (op_s == 2'b10);
   assign is_cmp_s  = (opc_s == 3'b101) && (op_s == 2'b01);
   assign is_ldr_s  = (opc_s == 3'b011) && (op_s == 2'b00);
   assign is_str_s  = (opc_s == 3'b100) && (op_s == 2'b00);
   assign is_b_s    = (opc_s == 3'b001) && (op_s == 2'b00);
   assign is_halt_s = (opc_s == 3'b111);

   assign bus.cond   = bus.IR[10:8];
   assign bus.sximm8 = {{(IMM_W-8){bus.IR[7]}}, bus.IR[7:0]};
   assign bus.sximm5 = {{(IMM_W-5){bus.IR[4]}}, bus.IR[4:0]};
   assign bus.ALUop  = (opc_s == 3'b101) ? op_s : 2'b00;

   // Next-state logic; reset overrides every transition.
   always_comb begin
      state_d = state_q;
      if (reset) begin
         state_d = RST;
      end else begin
         case (state_q)
            RST:   state_d = IF1;
            IF1:   state_d = IF2;
            IF2:   state_d = UPDPC;
            UPDPC: state_d = DEC;
            DEC: begin
               if (is_movi_s) begin
                  state_d = WRIMM;
               end else if (is_movr_s || is_mvn_s) begin
                  state_d = GETB;
               end else if (is_add_s || is_and_s || is_cmp_s || is_ldr_s || is_str_s) begin
                  state_d = GETA;
               end else if (is_b_s) begin
                  state_d = BR;
               end else if (is_halt_s) begin
                  state_d = HALT;
               end else begin
`ifdef CTRL_ILLEGAL_TRAP_EN
                  state_d = HALT;
`else
                  state_d = IF1;
`endif
               end
            end
            GETA:  state_d = (is_ldr_s || is_str_s) ? ADDR : GETB;
            GETB: begin
               if (is_movr_s || is_mvn_s) begin
                  state_d = MOVC;
               end else if (is_cmp_s) begin
                  state_d = CMPS;
               end else begin
                  state_d = ALUC;
               end
            end
            ADDR:  state_d = is_str_s ? GETBD : LDRRD;
            GETBD: state_d = STRWR;
            MOVC:  state_d = WRC;
            ALUC:  state_d = WRC;
            LDRRD: state_d = LDRWR;
            WRIMM, WRC, CMPS, LDRWR, STRWR, BR: state_d = IF1;
            HALT:  state_d = HALT;
            default: state_d = RST;
         endcase
      end
   end

   // Output decode of the upcoming state, so the registered outputs line up with state_q.
   always_comb begin
      loadir_d = 1'b0; incp_d = 1'b0; execb_d = 1'b0; msel_d = 1'b0; mwrite_d = 1'b0;
      write_d = 1'b0; loada_d = 1'b0; loadb_d = 1'b0; loadc_d = 1'b0; loads_d = 1'b0;
      asel_d = 1'b0; bsel_d = 1'b0; halted_d = 1'b0;
      readnum_d = 3'd0; writenum_d = 3'd0; vsel_d = 2'b00; shift_d = 2'b00;
      case (state_d)
         IF2:   loadir_d = 1'b1;
         UPDPC: incp_d = 1'b1;
         WRIMM: begin write_d = 1'b1; vsel_d = 2'b10; writenum_d = bus.IR[10:8]; end
         GETA:  begin loada_d = 1'b1; readnum_d = bus.IR[10:8]; end
         GETB:  begin loadb_d = 1'b1; readnum_d = bus.IR[2:0]; shift_d = bus.IR[4:3]; end
         GETBD: begin loadb_d = 1'b1; readnum_d = bus.IR[7:5]; end
         MOVC:  begin asel_d = 1'b1; loadc_d = 1'b1; shift_d = bus.IR[4:3]; end
         ALUC:  begin loadc_d = 1'b1; shift_d = bus.IR[4:3]; end
         CMPS:  begin loads_d = 1'b1; shift_d = bus.IR[4:3]; end
         WRC:   begin write_d = 1'b1; writenum_d = bus.IR[7:5]; end
         ADDR:  begin bsel_d = 1'b1; loadc_d = 1'b1; end
         LDRRD: msel_d = 1'b1;
         LDRWR: begin msel_d = 1'b1; write_d = 1'b1; vsel_d = 2'b11; writenum_d = bus.IR[7:5]; end
         STRWR: begin msel_d = 1'b1; mwrite_d = 1'b1; end
         BR:    execb_d = 1'b1;
         HALT:  halted_d = 1'b1;
         default: halted_d = 1'b0;
      endcase
   end

   // State and control output registers.
   always_ff @(posedge clk) begin
      state_q    <= state_d;
      loadir_q   <= loadir_d;  incp_q  <= incp_d;  execb_q  <= execb_d;
      msel_q     <= msel_d;    mwrite_q <= mwrite_d; write_q <= write_d;
      loada_q    <= loada_d;   loadb_q <= loadb_d; loadc_q  <= loadc_d;
      loads_q    <= loads_d;   asel_q  <= asel_d;  bsel_q   <= bsel_d;
      halted_q   <= halted_d;  readnum_q <= readnum_d; writenum_q <= writenum_d;
      vsel_q     <= vsel_d;    shift_q <= shift_d;
   end

   assign bus.loadir = loadir_q;  assign bus.incp   = incp_q;   assign bus.execb = execb_q;
   assign bus.msel   = msel_q;    assign bus.mwrite = mwrite_q; assign bus.write = write_q;
   assign bus.loada  = loada_q;   assign bus.loadb  = loadb_q;  assign bus.loadc = loadc_q;
   assign bus.loads  = loads_q;   assign bus.asel   = asel_q;   assign bus.bsel  = bsel_q;
   assign bus.halted = halted_q;  assign bus.readnum = readnum_q;
   assign bus.writenum = writenum_q; assign bus.vsel = vsel_q;  assign bus.shift = shift_q;

`ifdef CTRL_ILLEGAL_TRAP_EN
   logic illegal_q, illegal_d, undef_s;

   assign undef_s = !(is_movi_s || is_movr_s || is_mvn_s || is_add_s || is_and_s || is_cmp_s ||
                      is_ldr_s || is_str_s || is_b_s || is_halt_s);

   // Sticky trap flag, cleared only by reset.
   always_comb begin
      illegal_d = illegal_q;
      if (reset) begin
         illegal_d = 1'b0;
      end else if ((state_q == DEC) && undef_s) begin
         illegal_d = 1'b1;
      end else begin
         illegal_d = illegal_q;
      end
   end

   // Trap flag register.
   always_ff @(posedge clk) begin
      illegal_q <= illegal_d;
   end

   assign bus.illegal = illegal_q;
`else
   assign bus.illegal = 1'b0;
`endif
endmodule

// File: tb/tb_cpu_controller.sv
// Scoreboard bench for cpu_controller: the driver queues per-cycle expectations, a negedge monitor checks them.
module tb_cpu_controller;
   typedef struct packed {
      logic loadir, incp, execb, msel, mwrite, write, loada, loadb, loadc, loads, asel, bsel, halted;
      logic [2:0] readnum, writenum;
      logic [1:0] vsel, shift;
   } ctl_t;

   typedef struct {
      int          at;
      ctl_t        c;
      logic [15:0] sx8, sx5;
      logic [2:0]  cond;
      logic [1:0]  aluop;
      logic        ill;
      string       nm;
   } exp_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   int   base = 0;
   exp_t q[$];
   logic [15:0] e_sx8, e_sx5;
   logic [2:0]  e_cond;
   logic [1:0]  e_aluop;

   cpu_controller_if #(.IMM_W(16)) bus ();
   cpu_controller #(.IMM_W(16)) dut (.clk(clk), .reset(reset), .bus(bus));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic push(input int at, input ctl_t c, input string nm, input logic ill);
      exp_t e;
      e.at = at; e.c = c; e.nm = nm; e.ill = ill;
      e.sx8 = e_sx8; e.sx5 = e_sx5; e.cond = e_cond; e.aluop = e_aluop;
      q.push_back(e);
   endtask

   task automatic wait_until(input int t);
      while (cyc < t) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Reset with a new IR, then queue the common fetch sequence starting at base.
   task automatic start_instr(input logic [15:0] ir, input logic [15:0] s8, input logic [15:0] s5,
                              input logic [2:0] cd, input logic [1:0] alu);
      ctl_t c;
      @(posedge clk);
      #1;
      bus.IR = ir; reset = 1'b1;
      e_sx8 = s8; e_sx5 = s5; e_cond = cd; e_aluop = alu;
      c = '0; push(cyc + 1, c, "rst", 1'b0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      base = cyc + 1;
      c = '0;          push(base,     c, "if1", 1'b0);
      c.loadir = 1'b1; push(base + 1, c, "if2", 1'b0);
      c = '0; c.incp = 1'b1; push(base + 2, c, "updpc", 1'b0);
      c = '0;          push(base + 3, c, "dec", 1'b0);
   endtask

   // Monitor: compare every queued expectation in its cycle.
   initial begin
      forever begin
         @(negedge clk);
         while (q.size() > 0 && q[0].at <= cyc) begin
            exp_t e;
            ctl_t a;
            e = q.pop_front();
            a = '{bus.loadir, bus.incp, bus.execb, bus.msel, bus.mwrite, bus.write, bus.loada,
                  bus.loadb, bus.loadc, bus.loads, bus.asel, bus.bsel, bus.halted,
                  bus.readnum, bus.writenum, bus.vsel, bus.shift};
            checks = checks + 1;
            if (e.at != cyc) begin
               errors = errors + 1;
               $display("FAIL %s: expectation for cycle %0d missed (now %0d)", e.nm, e.at, cyc);
            end else if (a !== e.c || bus.illegal !== e.ill) begin
               errors = errors + 1;
               $display("FAIL %s ctl: got %h ill=%b, required %h ill=%b", e.nm, a, bus.illegal, e.c, e.ill);
            end
            checks = checks + 1;
            if (bus.sximm8 !== e.sx8 || bus.sximm5 !== e.sx5 || bus.cond !== e.cond || bus.ALUop !== e.aluop) begin
               errors = errors + 1;
               $display("FAIL %s fields: got sx8=%h sx5=%h cond=%b alu=%b, required sx8=%h sx5=%h cond=%b alu=%b",
                        e.nm, bus.sximm8, bus.sximm5, bus.cond, bus.ALUop, e.sx8, e.sx5, e.cond, e.aluop);
            end
         end
      end
   end

   initial begin
      ctl_t c;
      bus.IR = 16'h0000;
      e_sx8 = 16'h0000; e_sx5 = 16'h0000; e_cond = 3'd0; e_aluop = 2'd0;

      // MOV R3,#-5
      start_instr(16'b110_10_011_11111011, 16'hFFFB, 16'hFFFB, 3'b011, 2'b00);
      c = '0; c.write = 1'b1; c.vsel = 2'b10; c.writenum = 3'd3; push(base + 4, c, "movi_wr", 1'b0);
      c = '0; push(base + 5, c, "movi_if1", 1'b0);
      c = '0; c.loadir = 1'b1; push(base + 6, c, "movi_if2", 1'b0);
      wait_until(base + 7);

      // ADD R2,R1,R0,LSL#1
      start_instr(16'b101_00_001_010_01_000, 16'h0048, 16'h0008, 3'b001, 2'b00);
      c = '0; c.loada = 1'b1; c.readnum = 3'd1; push(base + 4, c, "add_geta", 1'b0);
      c = '0; c.loadb = 1'b1; c.readnum = 3'd0; c.shift = 2'b01; push(base + 5, c, "add_getb", 1'b0);
      c = '0; c.loadc = 1'b1; c.shift = 2'b01; push(base + 6, c, "add_aluc", 1'b0);
      c = '0; c.write = 1'b1; c.writenum = 3'd2; push(base + 7, c, "add_wrc", 1'b0);
      c = '0; push(base + 8, c, "add_if1", 1'b0);
      wait_until(base + 9);

      // LDR R5,[R1,#3]
      start_instr(16'b011_00_001_101_00011, 16'hFFA3, 16'h0003, 3'b001, 2'b00);
      c = '0; c.loada = 1'b1; c.readnum = 3'd1; push(base + 4, c, "ldr_geta", 1'b0);
      c = '0; c.loadc = 1'b1; c.bsel = 1'b1; push(base + 5, c, "ldr_addr", 1'b0);
      c = '0; c.msel = 1'b1; push(base + 6, c, "ldr_rd", 1'b0);
      c = '0; c.msel = 1'b1; c.write = 1'b1; c.vsel = 2'b11; c.writenum = 3'd5; push(base + 7, c, "ldr_wr", 1'b0);
      c = '0; push(base + 8, c, "ldr_if1", 1'b0);
      wait_until(base + 9);

      // B with cond 001, offset 4
      start_instr(16'b001_00_001_00000100, 16'h0004, 16'h0004, 3'b001, 2'b00);
      c = '0; c.execb = 1'b1; push(base + 4, c, "br", 1'b0);
      c = '0; push(base + 5, c, "br_if1", 1'b0);
      wait_until(base + 6);

      // MVN R4,R3,ASR
      start_instr(16'b101_11_000_100_10_011, 16'hFF93, 16'hFFF3, 3'b000, 2'b11);
      c = '0; c.loadb = 1'b1; c.readnum = 3'd3; c.shift = 2'b10; push(base + 4, c, "mvn_getb", 1'b0);
      c = '0; c.asel = 1'b1; c.loadc = 1'b1; c.shift = 2'b10; push(base + 5, c, "mvn_movc", 1'b0);
      c = '0; c.write = 1'b1; c.writenum = 3'd4; push(base + 6, c, "mvn_wrc", 1'b0);
      c = '0; push(base + 7, c, "mvn_if1", 1'b0);
      wait_until(base + 8);

      // CMP R2,R1
      start_instr(16'b101_01_010_000_00_001, 16'h0001, 16'h0001, 3'b010, 2'b01);
      c = '0; c.loada = 1'b1; c.readnum = 3'd2; push(base + 4, c, "cmp_geta", 1'b0);
      c = '0; c.loadb = 1'b1; c.readnum = 3'd1; push(base + 5, c, "cmp_getb", 1'b0);
      c = '0; c.loads = 1'b1; push(base + 6, c, "cmp_s", 1'b0);
      c = '0; push(base + 7, c, "cmp_if1", 1'b0);
      wait_until(base + 8);

      // STR R6,[R2,#2]
      start_instr(16'b100_00_010_110_00010, 16'hFFC2, 16'h0002, 3'b010, 2'b00);
      c = '0; c.loada = 1'b1; c.readnum = 3'd2; push(base + 4, c, "str_geta", 1'b0);
      c = '0; c.loadc = 1'b1; c.bsel = 1'b1; push(base + 5, c, "str_addr", 1'b0);
      c = '0; c.loadb = 1'b1; c.readnum = 3'd6; push(base + 6, c, "str_getbd", 1'b0);
      c = '0; c.msel = 1'b1; c.mwrite = 1'b1; push(base + 7, c, "str_wr", 1'b0);
      c = '0; push(base + 8, c, "str_if1", 1'b0);
      wait_until(base + 9);

      // HALT: absorbing, no further fetch
      start_instr(16'hE000, 16'h0000, 16'h0000, 3'b000, 2'b00);
      for (int i = 0; i < 12; i++) begin
         c = '0; c.halted = 1'b1; push(base + 4 + i, c, "halt", 1'b0);
      end
      wait_until(base + 16);

      // HALT with op=11 is still a defined encoding
      start_instr(16'b111_11_000_00000000, 16'h0000, 16'h0000, 3'b000, 2'b00);
      for (int i = 0; i < 4; i++) begin
         c = '0; c.halted = 1'b1; push(base + 4 + i, c, "halt11", 1'b0);
      end
      wait_until(base + 8);

      // Undefined encoding 000_00
      start_instr(16'h0000, 16'h0000, 16'h0000, 3'b000, 2'b00);
`ifdef CTRL_ILLEGAL_TRAP_EN
      for (int i = 0; i < 4; i++) begin
         c = '0; c.halted = 1'b1; push(base + 4 + i, c, "undef_trap", 1'b1);
      end
`else
      c = '0; push(base + 4, c, "undef_nop_if1", 1'b0);
      c = '0; c.loadir = 1'b1; push(base + 5, c, "undef_nop_if2", 1'b0);
`endif
      wait_until(base + 8);

      // Reset asserted during LDRRD
      start_instr(16'b011_00_001_101_00011, 16'hFFA3, 16'h0003, 3'b001, 2'b00);
      c = '0; c.loada = 1'b1; c.readnum = 3'd1; push(base + 4, c, "ldr2_geta", 1'b0);
      c = '0; c.loadc = 1'b1; c.bsel = 1'b1; push(base + 5, c, "ldr2_addr", 1'b0);
      c = '0; c.msel = 1'b1; push(base + 6, c, "ldr2_rd", 1'b0);
      wait_until(base + 6);
      reset = 1'b1;
      c = '0; push(cyc + 1, c, "midrst_rst", 1'b0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      c = '0; push(cyc + 1, c, "midrst_if1", 1'b0);
      c = '0; c.loadir = 1'b1; push(cyc + 2, c, "midrst_if2", 1'b0);
      wait_until(cyc + 4);

      @(posedge clk);
      @(negedge clk);
      checks = checks + 1;
      if (q.size() != 0) begin
         errors = errors + 1;
         $display("FAIL drain: %0d expectations left unchecked, required 0", q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/cpu_controller.md
# cpu_controller

Instruction-sequencing state machine for the 16-bit lab CPU. Sits directly downstream of the program-counter/instruction-memory stage. It consumes the latched instruction register and drives that stage's `loadir`, `incp`, `execb`, `msel`, `mwrite` and `cond` inputs. It also drives the register-file/ALU datapath controls, so that fetch, decode and multi-cycle execute run in a fixed Moore sequence.

## Interface
- `IMM_W`, default 16: width of the sign-extended immediate outputs.
- `clk` in 1: single clock, all state updates on rising edge.
- `reset` in 1: synchronous, active-high; forces state RST.
- `IR` in 16: instruction register. Fields: opcode=IR[15:13], op=IR[12:11], Rn=IR[10:8], Rd=IR[7:5], shift=IR[4:3], Rm=IR[2:0].
- `loadir`, `incp`, `execb`, `msel`, `mwrite` out 1: fetch/memory controls to the PC stage.
- `cond` out 3: IR[10:8], combinational.
- `sximm8` out IMM_W: sign-extended IR[7:0], combinational.
- `sximm5` out IMM_W: sign-extended IR[4:0], combinational.
- `readnum`, `writenum` out 3: register selects (state-gated, 0 when unused).
- `write`, `loada`, `loadb`, `loadc`, `loads`, `asel`, `bsel` out 1: datapath controls.
- `vsel` out 2: write-back source. 00=C, 10=sximm8, 11=mdata, 01 unused.
- `ALUop` out 2: IR[12:11] when opcode=101, else 00.
- `shift` out 2: IR[4:3] in GETB, ALUC, CMPS, MOVC, else 00.
- `halted` out 1: high in HALT.
- `illegal` out 1: see Configuration.

## Operation
- Moore FSM; every control output is a function of state plus IR fields only. Unlisted outputs are 0 in each state.
- Fetch:
  - RST → IF1.
  - IF1: `msel`=0.
  - IF2: `loadir`=1.
  - UPDPC: `incp`=1.
  - DEC: no controls; dispatches to the execute path for the instruction.
- MOV imm (110,10): WRIMM (`write`, `vsel`=10, `writenum`=Rn) → IF1.
- MOV reg (110,00) and MVN (101,11): GETB (`loadb`, `readnum`=Rm) → MOVC (`asel`=1, `bsel`=0, `loadc`) → WRC (`write`, `vsel`=00, `writenum`=Rd) → IF1.
- ADD (101,00) and AND (101,10): GETA (`loada`, `readnum`=Rn) → GETB → ALUC (`asel`=0, `bsel`=0, `loadc`) → WRC → IF1.
- CMP (101,01): GETA → GETB → CMPS (`loads`, `asel`=0, `bsel`=0) → IF1.
- LDR (011,00): GETA → ADDR (`bsel`=1, `loadc`, `ALUop`=00) → LDRRD (`msel`=1) → LDRWR (`msel`=1, `write`, `vsel`=11, `writenum`=Rd) → IF1.
- STR (100,00): GETA → ADDR → GETBD (`loadb`, `readnum`=Rd) → STRWR (`msel`=1, `mwrite`=1) → IF1.
- B (001,00): BR (`execb`=1, one cycle) → IF1. The taken decision belongs to the PC stage.
- HALT (111,xx): HALT state, absorbing until `reset`.
- Any other opcode/op combination is undefined; behaviour is set by the Configuration macro.

## Timing
- Reset: `reset` sampled high at an edge → state RST on the next cycle. All state-gated outputs are 0 in RST. `cond`/`sximm8`/`sximm5` track IR.
- Reset mid-operation: wins over every transition. A pending `mwrite` or `write` is dropped in the cycle after the edge.
- Fetch overhead: 4 cycles (IF1, IF2, UPDPC, DEC). IR is valid from the cycle DEC begins.
- Total cycles per instruction, from IF1: MOV imm 5, B 5, MOV reg 7, MVN 7, CMP 7, ADD 8, AND 8, LDR 8, STR 8.
- RAM read latency is 1 cycle. `msel` is held across LDRRD and LDRWR so that `mdata` stays stable while it is written back.
- `execb`, `mwrite`, `write` and `incp` are each high for exactly one cycle per instruction.

## Configuration
- `CTRL_ILLEGAL_TRAP_EN` defined: an undefined encoding in DEC goes to HALT, and `illegal` is set and held high until `reset`.
- `CTRL_ILLEGAL_TRAP_EN` undefined: an undefined encoding is a NOP (DEC → IF1), and `illegal` is tied 0.

## Test plan
- Reset then fetch: `reset`=1 for one edge, then 0. Required sequence: `msel`=0 with all else 0 → `loadir`=1 → `incp`=1 → all 0 (DEC).
- MOV R3,#-5 (IR=16'b110_10_011_11111011): in the cycle after DEC, `write`=1, `vsel`=10, `writenum`=3, `sximm8`=16'hFFFB; next state IF1.
- ADD R2,R1,R0,LSL#1 (IR=16'b101_00_001_010_01_000): the following cycles in order:
  - `loada`, `readnum`=1.
  - `loadb`, `readnum`=0, `shift`=01.
  - `loadc`, `ALUop`=00.
  - `write`, `writenum`=2, `vsel`=00.
- LDR R5,[R1,#3] (IR=16'b011_00_001_101_00011): the following cycles in order:
  - `loada`, `readnum`=1.
  - `loadc`, `bsel`=1, `sximm5`=3.
  - `msel`=1.
  - `msel`=1, `write`, `vsel`=11, `writenum`=5.
- B with cond 001 (IR=16'b001_00_001_00000100): `execb`=1 for exactly one cycle with `cond`=001 and `sximm8`=4, then IF1.
- HALT and reset:
  - IR=16'hE000: `halted`=1 for 10+ cycles with no `incp`.
  - Separately, `reset`=1 during LDRRD: RST next cycle, all controls 0.
  - Run once per macro setting with IR=16'b111_11_000_00000000 and check `illegal`.
